flash_arbiter: RTL

- Shares the single SPI flash read controller between two requesters: port 0 (instruction fetch) and port 1 (data load).
- Arbitrates round-robin between the ports.
- Drives the controller's edge-triggered `read_enable` / `data_valid` protocol and retries reads the controller does not start.
- Holds a one-word last-read cache, so a repeated access to the same word returns without a flash transaction.
- Sits between the CPU fetch/load units and the flash controller.

---
 rtl/flash_arb_pkg.sv | 19 +
 rtl/rr_arb2.sv | 35 +++
 rtl/flash_arbiter.sv | 212 +++++++++++++++++++++
 3 files changed

// File: rtl/flash_arb_pkg.sv
// Shared types and constants for the two-port SPI flash read arbiter.
package flash_arb_pkg;

    typedef enum logic [2:0] {
        IDLE,
        ISSUE,
        WAIT_BUSY,
        WAIT_DONE,
        GAP,
        RESP
    } state_e;

    localparam logic [31:0] ERR_DATA          = 32'hFFFF_FFFF;
    localparam int          DEFAULT_TIMEOUT   = 32;
    localparam int          DEFAULT_MAX_RETRY = 2;
    localparam int          CNT_W             = 16;
    localparam int          RETRY_W           = 8;

endpackage

// File: rtl/rr_arb2.sv
// Two-requester round-robin: combinational grant, registered last-grant
// pointer that only moves when the owner says a grant completed.
module rr_arb2 (
    input  logic       clk,
    input  logic       rst,
    input  logic [1:0] req,
    input  logic       upd_en,
    input  logic       upd_idx,
    output logic       gnt_valid,
    output logic       gnt_idx
);

    logic last_grant_q;
    logic last_grant_d;

    always_comb begin
        gnt_valid = |req;
        if (req == 2'b11) begin
            gnt_idx = ~last_grant_q;
        end else begin
            gnt_idx = req[1];
        end
        last_grant_d = upd_en ? upd_idx : last_grant_q;
    end

    // Resets to port 1 so that port 0 wins the first contested grant.
    always_ff @(posedge clk) begin
        if (!rst) begin
            last_grant_q <= 1'b1;
        end else begin
            last_grant_q <= last_grant_d;
        end
    end

endmodule

// File: rtl/flash_arbiter.sv
// Shares one SPI flash read controller between instruction fetch (port 0)
// and data load (port 1), with retry on missed starts and a one-word cache.
module flash_arbiter
    import flash_arb_pkg::*;
#(
    parameter int TIMEOUT   = DEFAULT_TIMEOUT,
    parameter int MAX_RETRY = DEFAULT_MAX_RETRY
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req0,
    input  logic        req1,
    input  logic [15:0] addr0,
    input  logic [15:0] addr1,
    output logic        ack0,
    output logic        ack1,
    output logic [31:0] rdata0,
    output logic [31:0] rdata1,
    output logic        err,
    input  logic        invalidate,
    output logic [15:0] flash_addr,
    output logic        flash_read_enable,
    input  logic [31:0] flash_data,
    input  logic        flash_data_valid,
    input  logic        flash_busy
);

    state_e state_q, state_d;

    logic               gnt_valid;
    logic               gnt_idx;
    logic [15:0]        win_addr;
    logic               cache_hit;
    logic               tmo_done;
    logic               retry_left;

    logic               port_q, port_d;
    logic [15:0]        addr_q, addr_d;
    logic [CNT_W-1:0]   tmo_cnt_q, tmo_cnt_d;
    logic [RETRY_W-1:0] retry_q, retry_d;
    logic               gap_q, gap_d;
    logic               cache_valid_q, cache_valid_d;
    logic [15:0]        cache_addr_q, cache_addr_d;
    logic [31:0]        cache_data_q, cache_data_d;
    logic               ack0_q, ack0_d;
    logic               ack1_q, ack1_d;
    logic               err_q, err_d;
    logic [31:0]        rdata0_q, rdata0_d;
    logic [31:0]        rdata1_q, rdata1_d;
    logic [15:0]        flash_addr_q, flash_addr_d;
    logic               read_en_q, read_en_d;

    logic               resp_port;
    logic [31:0]        resp_data;

    rr_arb2 u_rr_arb2 (
        .clk       (clk),
        .rst       (rst),
        .req       ({req1, req0}),
        .upd_en    (state_q == RESP),
        .upd_idx   (port_q),
        .gnt_valid (gnt_valid),
        .gnt_idx   (gnt_idx)
    );

    assign win_addr   = gnt_idx ? addr1 : addr0;
    assign cache_hit  = cache_valid_q && (cache_addr_q == win_addr);
    assign tmo_done   = (tmo_cnt_q == CNT_W'(TIMEOUT - 1));
    assign retry_left = (retry_q < RETRY_W'(MAX_RETRY));

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q       <= IDLE;
            port_q        <= 1'b0;
            addr_q        <= '0;
            tmo_cnt_q     <= '0;
            retry_q       <= '0;
            gap_q         <= 1'b0;
            cache_valid_q <= 1'b0;
            cache_addr_q  <= '0;
            cache_data_q  <= '0;
            ack0_q        <= 1'b0;
            ack1_q        <= 1'b0;
            err_q         <= 1'b0;
            rdata0_q      <= '0;
            rdata1_q      <= '0;
            flash_addr_q  <= '0;
            read_en_q     <= 1'b0;
        end else begin
            state_q       <= state_d;
            port_q        <= port_d;
            addr_q        <= addr_d;
            tmo_cnt_q     <= tmo_cnt_d;
            retry_q       <= retry_d;
            gap_q         <= gap_d;
            cache_valid_q <= cache_valid_d;
            cache_addr_q  <= cache_addr_d;
            cache_data_q  <= cache_data_d;
            ack0_q        <= ack0_d;
            ack1_q        <= ack1_d;
            err_q         <= err_d;
            rdata0_q      <= rdata0_d;
            rdata1_q      <= rdata1_d;
            flash_addr_q  <= flash_addr_d;
            read_en_q     <= read_en_d;
        end
    end

    // IDLE also waits out a controller still busy from before our reset.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: begin
                if (!flash_busy && gnt_valid) begin
                    state_d = cache_hit ? RESP : ISSUE;
                end
            end
            ISSUE:     state_d = WAIT_BUSY;
            WAIT_BUSY: begin
                if (flash_busy) begin
                    state_d = WAIT_DONE;
                end else if (tmo_done) begin
                    state_d = retry_left ? GAP : RESP;
                end
            end
            GAP: begin
                if (gap_q) begin
                    state_d = ISSUE;
                end
            end
            WAIT_DONE: begin
                if (flash_data_valid) begin
                    state_d = RESP;
                end
            end
            RESP:      state_d = IDLE;
            default:   state_d = IDLE;
        endcase
    end

    // Outputs are computed from the upcoming state so every port is a flop.
    always_comb begin
        port_d        = port_q;
        addr_d        = addr_q;
        flash_addr_d  = flash_addr_q;
        tmo_cnt_d     = tmo_cnt_q;
        retry_d       = retry_q;
        gap_d         = (state_q == GAP);
        cache_valid_d = cache_valid_q;
        cache_addr_d  = cache_addr_q;
        cache_data_d  = cache_data_q;
        ack0_d        = 1'b0;
        ack1_d        = 1'b0;
        err_d         = 1'b0;
        rdata0_d      = rdata0_q;
        rdata1_d      = rdata1_q;
        read_en_d     = (state_d == ISSUE) || (state_d == WAIT_BUSY);
        resp_port     = port_q;
        resp_data     = flash_data;

        if (state_q == IDLE && state_d != IDLE) begin
            port_d    = gnt_idx;
            addr_d    = win_addr;
            resp_port = gnt_idx;
            resp_data = cache_data_q;
            if (state_d == ISSUE) begin
                flash_addr_d = win_addr;
            end
        end

        if (state_q == ISSUE) begin
            tmo_cnt_d = '0;
        end else if (state_q == WAIT_BUSY) begin
            tmo_cnt_d = tmo_cnt_q + 1'b1;
            resp_data = ERR_DATA;
            if (state_d == GAP) begin
                retry_d = retry_q + 1'b1;
            end
        end else if (state_q == RESP) begin
            retry_d = '0;
        end

        if (state_d == RESP) begin
            err_d = (state_q == WAIT_BUSY);
            if (resp_port) begin
                ack1_d   = 1'b1;
                rdata1_d = resp_data;
            end else begin
                ack0_d   = 1'b1;
                rdata0_d = resp_data;
            end
        end

        if (state_q == WAIT_DONE && flash_data_valid) begin
            cache_valid_d = 1'b1;
            cache_addr_d  = addr_q;
            cache_data_d  = flash_data;
        end
        if (invalidate) begin
            cache_valid_d = 1'b0;
        end
    end

    assign ack0              = ack0_q;
    assign ack1              = ack1_q;
    assign err               = err_q;
    assign rdata0            = rdata0_q;
    assign rdata1            = rdata1_q;
    assign flash_addr        = flash_addr_q;
    assign flash_read_enable = read_en_q;

endmodule
